// File: rtl/keystream_xor_pkg.sv
// Shared constants and FSM state encoding for the keystream XOR stage.
package keystream_xor_pkg;
  localparam int unsigned QUEUE_DEPTH     = 2;
  localparam int unsigned DEFAULT_DATA_W  = 8;
  localparam int unsigned DEFAULT_COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_KS = 2'd1,
    ST_WRITE   = 2'd2
  } state_e;
endpackage

// File: rtl/byte_skid_queue.sv
// Two-entry FIFO; a push is accepted when not full or when popped in the same cycle.
module byte_skid_queue
  import keystream_xor_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [QUEUE_DEPTH];
  logic [DATA_W-1:0] mem_d [QUEUE_DEPTH];
  logic [1:0]        count_q, count_d;
  logic              push_ok, pop_ok;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q < 2'(QUEUE_DEPTH)) || pop_ok);
    unique case ({push_ok, pop_ok})
      2'b10: begin
        mem_d[count_q[0]] = din;
        count_d           = count_q + 2'd1;
      end
      2'b01: begin
        mem_d[0] = mem_q[1];
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous pop+push: count is unchanged, the new byte lands behind the survivor.
        if (count_q == 2'd1) begin
          mem_d[0] = din;
        end else begin
          mem_d[0] = mem_q[1];
          mem_d[1] = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[0];
  assign count = count_q;
  assign full  = (count_q == 2'(QUEUE_DEPTH));
  assign empty = (count_q == 2'd0);
endmodule

// File: rtl/keystream_xor_stage.sv
// Queues received bytes, XORs each with one keystream byte (or bypasses), and writes downstream.
module keystream_xor_stage
  import keystream_xor_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned COUNT_W = DEFAULT_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               enable,
  input  logic               bypass,
  input  logic               ks_valid,
  input  logic [DATA_W-1:0]  ks_byte,
  output logic               ks_read,
  input  logic               fifo_full,
  output logic               wr_en,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               overflow,
  output logic [COUNT_W-1:0] byte_count
);
  state_e             state_q, state_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               overflow_q, overflow_d;
  logic [COUNT_W-1:0] byte_count_q, byte_count_d;

  logic               q_push, q_pop, q_full, q_empty;
  logic [1:0]         q_count;
  logic [DATA_W-1:0]  q_head;

  byte_skid_queue #(.DATA_W(DATA_W)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   (in_data),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    state_d      = state_q;
    wr_data_d    = wr_data_q;
    overflow_d   = overflow_q;
    byte_count_d = byte_count_q;
    ks_read      = 1'b0;
    wr_en        = 1'b0;
    q_pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && !q_empty) state_d = ST_WAIT_KS;
      end
      ST_WAIT_KS: begin
        if (bypass) begin
          wr_data_d = q_head;
          q_pop     = 1'b1;
          state_d   = ST_WRITE;
        end else if (ks_valid) begin
          ks_read   = 1'b1;
          wr_data_d = q_head ^ ks_byte;
          q_pop     = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!fifo_full) begin
          wr_en        = 1'b1;
          byte_count_d = byte_count_q + 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    q_push = in_valid && (!q_full || q_pop);
    if (in_valid && q_full && !q_pop) overflow_d = 1'b1;
    // Reset cycle: suppress every strobe so nothing is consumed, written or queued.
    if (rst) begin
      ks_read = 1'b0;
      wr_en   = 1'b0;
      q_push  = 1'b0;
      q_pop   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_data_q    <= wr_data_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign busy       = (q_count != 2'd0) || (state_q != ST_IDLE);
  assign wr_data    = wr_data_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;
endmodule

// File: tb/tb_keystream_xor_stage.sv
// Scoreboard bench: expected ciphertext queued at issue, popped by a monitor on each wr_en.
module tb_keystream_xor_stage;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, enable, bypass, ks_valid, fifo_full;
  logic [DW-1:0] in_data, ks_byte, wr_data;
  logic          ks_read, wr_en, busy, overflow;
  logic [CW-1:0] byte_count;

  always #5 clk = ~clk;

  keystream_xor_stage #(.DATA_W(DW), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .enable(enable), .bypass(bypass), .ks_valid(ks_valid), .ks_byte(ks_byte),
    .ks_read(ks_read), .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .overflow(overflow), .byte_count(byte_count)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ks_arr [1024];
  int            ks_idx  = 0;
  int            ks_next = 0;
  int            ks_reads = 0;
  int            writes   = 0;
  int            cyc = 0;
  int            last_ks_cyc = -1;
  int            last_wr_cyc = -1;
  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] cnt_model = '0;

  assign ks_byte = ks_arr[ks_idx[9:0]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      exp_q.delete();
      cnt_model = '0;
    end else begin
      if (ks_read || wr_en) begin
        total++;
        if (ks_read && wr_en) begin
          bad++;
          $display("FAIL strobe_overlap: ks_read=%0b wr_en=%0b required not both", ks_read, wr_en);
        end
      end
      if (ks_read) begin
        ks_reads++;
        last_ks_cyc = cyc;
      end
      if (wr_en) begin
        writes++;
        last_wr_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got wr_data=%02h with no byte expected", wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_data !== e) begin
            bad++;
            $display("FAIL wr_data: got %02h expected %02h", wr_data, e);
          end
        end
        total++;
        if (byte_count !== cnt_model) begin
          bad++;
          $display("FAIL byte_count_at_write: got %0d expected %0d", byte_count, cnt_model);
        end
        cnt_model = cnt_model + 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ks_idx = ks_reads;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_raw(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    if (bypass) exp_q.push_back(d);
    else begin
      exp_q.push_back(d ^ ks_arr[ks_next]);
      ks_next++;
    end
    send_raw(d);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit done = 0;
    for (int i = 0; i < limit; i++) begin
      if (!busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
      step();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d expected idle", name, busy, exp_q.size());
    end
  endtask

  task automatic wait_ks_read(input string name, input int r0);
    for (int i = 0; i < 20 && ks_reads == r0; i++) step();
    check({name, "_ks_read_seen"}, ks_reads, r0 + 1);
  endtask

  initial begin
    int n, r0, w0;
    logic [DW-1:0] wd;
    for (int i = 0; i < 1024; i++) ks_arr[i] = DW'($urandom);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; enable = 1'b1; bypass = 1'b0;
    ks_valid = 1'b1; fifo_full = 1'b0;

    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_ks_read", ks_read, 0);
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_wr_data", wr_data, 0);

    // Single byte latency and value
    ks_arr[ks_next] = 8'h5A;
    n = cyc;
    send(8'h41);
    wait_idle("single", 20);
    check("single_ks_read_cycle", last_ks_cyc, n + 2);
    check("single_wr_en_cycle", last_wr_cyc, n + 3);
    check("single_wr_data", wr_data, 8'h1B);
    check("single_byte_count", byte_count, 1);

    // Bypass: no keystream consumed
    bypass = 1'b1; ks_valid = 1'b0;
    r0 = ks_reads;
    send(8'h41);
    wait_idle("bypass", 20);
    check("bypass_wr_data", wr_data, 8'h41);
    check("bypass_no_ks_read", ks_reads, r0);
    bypass = 1'b0; ks_valid = 1'b1;

    // Backpressure after keystream consumed
    fifo_full = 1'b1;
    r0 = ks_reads; w0 = writes;
    send(8'hC3);
    wait_ks_read("bp", r0);
    wd = wr_data;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_wr_en_held", wr_en, 0);
      check("bp_wr_data_stable", wr_data, wd);
    end
    check("bp_no_write", writes, w0);
    fifo_full = 1'b0;
    wait_idle("bp", 20);
    check("bp_one_write", writes, w0 + 1);
    check("bp_one_ks_read", ks_reads, r0 + 1);

    // Overflow: third byte dropped while held idle
    enable = 1'b0;
    w0 = writes;
    send(8'h01);
    send(8'h02);
    send_raw(8'h03);
    check("ovf_flag", overflow, 1);
    check("ovf_busy", busy, 1);
    enable = 1'b1;
    wait_idle("ovf", 30);
    check("ovf_two_writes", writes, w0 + 2);
    check("ovf_sticky", overflow, 1);

    // Keystream stall
    ks_valid = 1'b0;
    r0 = ks_reads; w0 = writes;
    send(8'h77);
    repeat (20) step();
    check("stall_busy", busy, 1);
    check("stall_no_write", writes, w0);
    check("stall_no_ks_read", ks_reads, r0);
    ks_valid = 1'b1;
    wait_idle("stall", 20);
    check("stall_one_ks_read", ks_reads, r0 + 1);
    check("stall_one_write", writes, w0 + 1);

    // Reset while stuck in WRITE
    fifo_full = 1'b1;
    r0 = ks_reads;
    send(8'h99);
    wait_ks_read("rstmid", r0);
    w0 = writes;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    check("rstmid_wr_en", wr_en, 0);
    check("rstmid_ks_read", ks_read, 0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_byte_count", byte_count, 0);
    check("rstmid_overflow", overflow, 0);
    fifo_full = 1'b0;
    repeat (5) step();
    check("rstmid_no_write", writes, w0);

    // Randomised traffic; byte_count wraps with the narrow counter
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0 && $urandom_range(0, 9) == 0) bypass = 1'($urandom_range(0, 1));
      enable    = ($urandom_range(0, 4) != 0);
      ks_valid  = ($urandom_range(0, 3) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      if (exp_q.size() < 2 && $urandom_range(0, 1) == 1) send(DW'($urandom));
      else step();
    end
    enable = 1'b1; ks_valid = 1'b1; fifo_full = 1'b0;
    wait_idle("random", 100);
    check("random_byte_count", byte_count, cnt_model);
    check("random_no_overflow", overflow, 0);
    check("random_ks_consumed", ks_reads, ks_next);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/keystream_xor_stage.md
KEYSTREAM_XOR_STAGE -- requirements
Module: keystream_xor_stage

Interface
REQ-001 Parameter: DATA_W, default 8, byte width of payload and keystream.
REQ-002 Parameter: COUNT_W, default 16, width of byte_count.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  one-cycle strobe; in_data holds a received plaintext byte.
REQ-006 Port: in_data  input  DATA_W  received byte.
REQ-007 Port: enable  input  1  high = FSM may process queued bytes; low = hold in IDLE.
REQ-008 Port: bypass  input  1  high = forward byte unmodified, consume no keystream.
REQ-009 Port: ks_valid  input  1  level; ks_byte holds a fresh keystream byte.
REQ-010 Port: ks_byte  input  DATA_W  keystream byte.
REQ-011 Port: ks_read  output  1  one-cycle pulse consuming current ks_byte.
REQ-012 Port: fifo_full  input  1  downstream FIFO cannot accept a write.
REQ-013 Port: wr_en  output  1  one-cycle write strobe to downstream FIFO.
REQ-014 Port: wr_data  output  DATA_W  ciphertext byte, valid while wr_en high.
REQ-015 Port: busy  output  1  high when queue non-empty or state != IDLE.
REQ-016 Port: overflow  output  1  sticky; a byte was dropped on a full queue.
REQ-017 Port: byte_count  output  COUNT_W  number of wr_en pulses issued.

Function
REQ-018 Input queue SHALL hold 2 entries, FIFO order; in_valid pushes in_data when count<2 or when a pop occurs in the same cycle.
REQ-019 in_valid with queue full and no same-cycle pop SHALL drop the byte and set overflow; queue contents unchanged.
REQ-020 FSM states SHALL be IDLE, WAIT_KS, WRITE.
REQ-021 IDLE -> WAIT_KS when enable=1 and queue non-empty; otherwise remain IDLE.
REQ-022 In WAIT_KS with bypass=0: ks_read = ks_valid (combinational); on that cycle latch wr_data = head XOR ks_byte, pop queue, go WRITE; without ks_valid, remain WAIT_KS.
REQ-023 In WAIT_KS with bypass=1: latch wr_data = head, pop queue, go WRITE next cycle; ks_read stays 0.
REQ-024 bypass and enable SHALL be sampled only at the transitions that use them; changes mid-byte do not alter a latched wr_data.
REQ-025 In WRITE: wr_en = !fifo_full (combinational); when wr_en=1 go IDLE; when fifo_full=1 hold WRITE with wr_data stable.
REQ-026 Latency: with enable=1, bypass=0, ks_valid=1, fifo_full=0, empty queue, in_valid at cycle N SHALL yield ks_read at N+2 and wr_en at N+3.
REQ-027 ks_read and wr_en SHALL never be asserted in the same cycle and SHALL each be at most one cycle per byte.
REQ-028 byte_count SHALL increment by 1 per wr_en cycle, wrapping from all-ones to 0.
REQ-029 Exactly one keystream byte SHALL be consumed per non-bypass byte; no keystream byte is consumed while idle.

Reset
REQ-030 rst=1 SHALL clear queue, state to IDLE, wr_data to 0, overflow to 0, byte_count to 0.
REQ-031 During the rst cycle ks_read=0 and wr_en=0, regardless of state or inputs; in_valid is ignored.
REQ-032 Reset mid-operation SHALL discard queued and latched bytes without a write.

Structure
REQ-033 Shared package keystream_xor_pkg SHALL hold the FSM state encoding, QUEUE_DEPTH=2 and default DATA_W/COUNT_W constants.
REQ-034 The 2-entry queue SHALL be a sub-module byte_skid_queue (push, pop, head, count, full, empty).
REQ-035 All state SHALL be registered in clk domain; only ks_read, wr_en and busy may be combinational decodes of registered state plus inputs.

Verification
REQ-036 Single byte: in_data=0x41, ks_byte=0x5A, ks_valid=1 -> ks_read at N+2, wr_en at N+3 with wr_data=0x1B, byte_count=1.
REQ-037 Bypass: bypass=1, in_data=0x41, ks_valid=0 -> wr_data=0x41, ks_read never asserted.
REQ-038 Backpressure: fifo_full=1 for 10 cycles after keystream consumed -> wr_en held 0, wr_data stable, single wr_en after release, one ks_read total.
REQ-039 Overflow: enable=0, three in_valid strobes 0x01,0x02,0x03 -> overflow=1; enable=1 -> outputs 0x01^ks, 0x02^ks only.
REQ-040 Keystream stall: ks_valid=0 for 20 cycles -> state WAIT_KS, busy=1, no wr_en; ks_valid=1 -> single ks_read then wr_en.
REQ-041 Reset mid-op: assert rst while in WRITE with fifo_full=1 -> no wr_en, busy=0, byte_count=0, overflow=0 next cycle.
